// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: op codes, FSM states and
// the layout of the command word held in the FIFO.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Command word is {tag, op, b, a}; the tag sits above the fixed 18-bit body.
    localparam int CMD_BASE_W = 18;
    localparam int A_LSB      = 0;
    localparam int B_LSB      = 8;
    localparam int OP_LSB     = 16;
    localparam int TAG_LSB    = 18;

    function automatic int cmd_w(input int tag_w);
        return tag_w + CMD_BASE_W;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular-buffer FIFO holding queued ALU commands; pointers wrap modulo DEPTH
// and the occupancy count runs 0..DEPTH.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the cleared count/pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues queued tagged commands to an external combinational ALU from registered
// outputs and returns tagged responses, counting divide-by-zero errors.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 4,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [7:0]          cmd_a,
    input  logic [7:0]          cmd_b,
    input  logic [1:0]          cmd_op,
    input  logic [TAG_W-1:0]    cmd_tag,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic [1:0]          alu_op,
    input  logic [15:0]         alu_result,
    input  logic                alu_error,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [15:0]         rsp_result,
    output logic                rsp_error,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic                busy
);

    localparam int CMD_W = cmd_w(TAG_W);

    state_e              state_q, state_d;
    logic [7:0]          alu_a_q, alu_a_d;
    logic [7:0]          alu_b_q, alu_b_d;
    logic [1:0]          alu_op_q, alu_op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [15:0]         rsp_result_q, rsp_result_d;
    logic                rsp_error_q, rsp_error_d;
    logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                  fifo_full, fifo_empty, fifo_pop, issue;
    logic [CMD_W-1:0]      fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_valid && cmd_ready),
        .wr_data ({cmd_tag, cmd_op, cmd_b, cmd_a}),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign cmd_ready  = !fifo_full;
    assign busy       = (state_q != S_IDLE) || (fifo_count != '0);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;
    assign rsp_tag    = rsp_tag_q;
    assign err_cnt    = err_cnt_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        tag_d        = tag_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        rsp_tag_d    = rsp_tag_q;
        err_cnt_d    = err_cnt_q;
        issue        = 1'b0;

        unique case (state_q)
            S_IDLE: issue = !fifo_empty;
            S_EXEC: begin
                rsp_result_d = alu_result;
                rsp_error_d  = alu_error;
                rsp_tag_d    = tag_q;
                rsp_valid_d  = 1'b1;
                state_d      = S_RESP;
                if (alu_error && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    issue       = !fifo_empty;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shared issue path for both IDLE start and back-to-back issue from RESP.
        if (issue) begin
            alu_a_d  = fifo_head[A_LSB +: 8];
            alu_b_d  = fifo_head[B_LSB +: 8];
            alu_op_d = fifo_head[OP_LSB +: 2];
            tag_d    = fifo_head[TAG_LSB +: TAG_W];
            state_d  = S_EXEC;
        end
        fifo_pop = issue;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
            rsp_tag_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            tag_q        <= tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            rsp_tag_q    <= rsp_tag_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: wraps a behavioural 8-bit ALU and scores tagged
// responses against a queue of expected results filled at command time.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] res;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_a = '0, cmd_b = '0;
    logic [1:0]  cmd_op = '0;
    logic [3:0]  cmd_tag = '0;
    logic [7:0]  alu_a, alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_error;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_error;
    logic [3:0]  rsp_tag;
    logic [7:0]  err_cnt;
    logic        busy;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fails   = 0;
    int   exp_err   = 0;
    int   cyc       = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4), .ERRCNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .cmd_tag    (cmd_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_error  (alu_error),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .rsp_tag    (rsp_tag),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    // External combinational ALU
    always_comb begin
        alu_result = '0;
        alu_error  = 1'b0;
        case (alu_op)
            OP_ADD: alu_result = {8'h00, alu_a} + {8'h00, alu_b};
            OP_SUB: alu_result = {8'h00, alu_a} - {8'h00, alu_b};
            OP_MUL: alu_result = {8'h00, alu_a} * {8'h00, alu_b};
            default: begin
                if (alu_b == 8'h00) alu_error = 1'b1;
                else                alu_result = {8'h00, alu_a / alu_b};
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one command from a negedge; returns on the negedge after acceptance.
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic [3:0] tag, input logic [15:0] eres, input logic eerr);
        int w = 0;
        cmd_valid = 1'b1;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("push_accept", 32'(cmd_ready), 32'd1);
        if (cmd_ready) sb.push_back('{res: eres, err: eerr, tag: tag});
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Accept n responses with rsp_ready high, comparing each to the scoreboard head.
    task automatic collect(input int n, input bit gap_chk);
        int   last = 0;
        int   w;
        exp_t e;
        rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!rsp_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("rsp_timeout", 32'(rsp_valid), 32'd1);
            if (rsp_valid && sb.size() > 0) begin
                e = sb.pop_front();
                if (e.err && exp_err < 255) exp_err++;
                check("rsp_result", 32'(rsp_result), 32'(e.res));
                check("rsp_error", 32'(rsp_error), 32'(e.err));
                check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                check("err_cnt", 32'(err_cnt), 32'(exp_err));
                if (gap_chk && i > 0) check("rsp_gap", 32'(cyc - last), 32'd2);
                last = cyc;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stale;

        // Reset state
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // Single ADD with latency check
        push(8'd200, 8'd100, OP_ADD, 4'd3, 16'h012C, 1'b0);
        check("lat_edge_n", 32'(rsp_valid), 32'd0);
        check("busy_active", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_edge_n1", 32'(rsp_valid), 32'd0);
        check("alu_a_driven", 32'(alu_a), 32'd200);
        check("alu_op_driven", 32'(alu_op), 32'(OP_ADD));
        @(negedge clk);
        check("lat_edge_n2", 32'(rsp_valid), 32'd1);
        collect(1, 1'b0);

        // SUB then MUL, in order
        push(8'd5, 8'd10, OP_SUB, 4'd1, 16'hFFFB, 1'b0);
        push(8'd255, 8'd255, OP_MUL, 4'd2, 16'hFE01, 1'b0);
        collect(2, 1'b0);
        check("alu_hold_idle", 32'(alu_b), 32'd255);

        // Divide by zero, then a valid divide
        check("err_cnt_before_div0", 32'(err_cnt), 32'd0);
        push(8'd7, 8'd0, OP_DIV, 4'd4, 16'h0000, 1'b1);
        collect(1, 1'b0);
        check("err_cnt_after_div0", 32'(err_cnt), 32'd1);
        push(8'd9, 8'd2, OP_DIV, 4'd5, 16'h0004, 1'b0);
        collect(1, 1'b0);
        check("err_cnt_after_div", 32'(err_cnt), 32'd1);

        // Backpressure: one held in RESP, four fill the FIFO
        rsp_ready = 1'b0;
        push(8'd10, 8'd20, OP_ADD, 4'd6, 16'h001E, 1'b0);
        push(8'd3, 8'd4, OP_MUL, 4'd7, 16'h000C, 1'b0);
        push(8'd100, 8'd7, OP_DIV, 4'd8, 16'h000E, 1'b0);
        push(8'd1, 8'd2, OP_SUB, 4'd9, 16'hFFFF, 1'b0);
        push(8'd0, 8'd0, OP_ADD, 4'd10, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        check("hold_rsp_tag", 32'(rsp_tag), 32'd6);
        check("hold_rsp_result", 32'(rsp_result), 32'h001E);
        cmd_valid = 1'b1;
        cmd_a = 8'd1; cmd_b = 8'd1; cmd_op = OP_ADD; cmd_tag = 4'd15;
        repeat (3) @(negedge clk);
        check("sixth_not_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        collect(5, 1'b1);
        repeat (3) @(negedge clk);
        check("drain_no_extra", 32'(rsp_valid), 32'd0);
        check("drain_idle", 32'(busy), 32'd0);

        // Error-counter saturation
        for (int i = 0; i < 260; i++) begin
            push(8'(i), 8'd0, OP_DIV, 4'(i), 16'h0000, 1'b1);
            collect(1, 1'b0);
        end
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);

        // Async reset with one command in EXEC and two queued
        rsp_ready = 1'b0;
        push(8'd1, 8'd1, OP_ADD, 4'd1, 16'h0002, 1'b0);
        push(8'd2, 8'd2, OP_ADD, 4'd2, 16'h0004, 1'b0);
        push(8'd3, 8'd3, OP_ADD, 4'd3, 16'h0006, 1'b0);
        push(8'd4, 8'd4, OP_ADD, 4'd4, 16'h0008, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_alu_a", 32'(alu_a), 32'd0);
        check("arst_alu_b", 32'(alu_b), 32'd0);
        check("arst_alu_op", 32'(alu_op), 32'd0);
        check("arst_rsp_result", 32'(rsp_result), 32'd0);
        check("arst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("arst_rsp_error", 32'(rsp_error), 32'd0);
        check("arst_err_cnt", 32'(err_cnt), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        sb.delete();
        exp_err = 0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || busy) stale++;
        end
        check("no_stale_rsp", 32'(stale), 32'd0);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        push(8'd12, 8'd3, OP_ADD, 4'd7, 16'h000F, 1'b0);
        collect(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
